// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory controller.
// The device-register decode helper is only used when LC3_MMIO_EN is defined.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  function automatic logic is_mmio(input logic [15:0] a);
    return (a == KBSR_ADDR) || (a == KBDR_ADDR) || (a == DSR_ADDR) || (a == DDR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_mem_if.sv
// Datapath, SRAM and console signals of the LC-3 memory controller.
// master = datapath/SRAM/console side, slave = controller.
interface lc3_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_MIO_EN;
  logic              i_R_W;
  logic [ADDR_W-1:0] i_MAR;
  logic [DATA_W-1:0] i_MDR;
  logic [DATA_W-1:0] o_MDR_in;
  logic              o_R_Bit;
  logic              o_mem_ce;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [7:0]        i_kb_data;
  logic              i_kb_valid;
  logic [7:0]        o_dd_data;
  logic              o_dd_valid;
  logic              o_kb_int;

  modport master (
    output i_MIO_EN, i_R_W, i_MAR, i_MDR, i_mem_rdata, i_kb_data, i_kb_valid,
    input  o_MDR_in, o_R_Bit, o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata,
           o_dd_data, o_dd_valid, o_kb_int
  );

  modport slave (
    input  i_MIO_EN, i_R_W, i_MAR, i_MDR, i_mem_rdata, i_kb_data, i_kb_valid,
    output o_MDR_in, o_R_Bit, o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata,
           o_dd_data, o_dd_valid, o_kb_int
  );
endinterface

// File: rtl/lc3_mmio_regs.sv
// LC-3 console device registers (KBSR/KBDR/DSR/DDR); built only with LC3_MMIO_EN.
// xfer marks the final ACCESS cycle of a device-register transaction.
module lc3_mmio_regs
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        xfer,
  input  logic        rw,
  output logic [15:0] rdata,
  output logic [7:0]  dd_data,
  output logic        dd_valid,
  output logic        kb_int
);

  logic       kb_ready_q, kb_ready_d;
  logic       kb_ie_q, kb_ie_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic [7:0] dd_data_q, dd_data_d;
  logic       dd_valid_q, dd_valid_d;
  logic       kb_int_q, kb_int_d;
  logic       wdata_unused_s;

  assign wdata_unused_s = ^{wdata[15], wdata[13:8]};

  // Register read mux
  always_comb begin
    case (addr)
      KBSR_ADDR: rdata = {kb_ready_q, kb_ie_q, 14'd0};
      KBDR_ADDR: rdata = {8'd0, kbdr_q};
      DSR_ADDR:  rdata = 16'h8000;
      default:   rdata = 16'h0000;
    endcase
  end

  // Register updates; a new keystroke beats a simultaneous KBDR read
  always_comb begin
    kb_ready_d = kb_ready_q;
    kb_ie_d    = kb_ie_q;
    kbdr_d     = kbdr_q;
    dd_data_d  = dd_data_q;
    dd_valid_d = 1'b0;
    if (xfer && !rw && (addr == KBDR_ADDR)) begin
      kb_ready_d = 1'b0;
    end else begin
      kb_ready_d = kb_ready_q;
    end
    if (kb_valid) begin
      kb_ready_d = 1'b1;
      kbdr_d     = kb_data;
    end else begin
      kbdr_d = kbdr_q;
    end
    if (xfer && rw && (addr == KBSR_ADDR)) begin
      kb_ie_d = wdata[14];
    end else begin
      kb_ie_d = kb_ie_q;
    end
    if (xfer && rw && (addr == DDR_ADDR)) begin
      dd_data_d  = wdata[7:0];
      dd_valid_d = 1'b1;
    end else begin
      dd_data_d = dd_data_q;
    end
    kb_int_d = kb_ready_d & kb_ie_d;
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_ready_q <= 1'b0;
      kb_ie_q    <= 1'b0;
      kbdr_q     <= 8'd0;
      dd_data_q  <= 8'd0;
      dd_valid_q <= 1'b0;
      kb_int_q   <= 1'b0;
    end else begin
      kb_ready_q <= kb_ready_d;
      kb_ie_q    <= kb_ie_d;
      kbdr_q     <= kbdr_d;
      dd_data_q  <= dd_data_d;
      dd_valid_q <= dd_valid_d;
      kb_int_q   <= kb_int_d;
    end
  end

  assign dd_data  = dd_data_q;
  assign dd_valid = dd_valid_q;
  assign kb_int   = kb_int_q;

endmodule

// File: rtl/lc3_memory_ctrl.sv
// LC-3 memory interface: fixed-latency SRAM sequencing and R-bit generation.
// Define LC3_MMIO_EN to decode the console device registers at xFE00-xFE06.
module lc3_memory_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic       i_CLK,
  input  logic       i_Reset,
  lc3_mem_if.slave   bus
);

  localparam int WAIT_CLAMP = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                              (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CLAMP - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              rw_q, rw_d;
  logic              mmio_q, mmio_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic              r_q, r_d;
  logic              mar_mmio_s;
  logic [DATA_W-1:0] mmio_rdata_s;

`ifdef LC3_MMIO_EN
  logic        mmio_xfer_s;
  logic [15:0] mmio_rdata16_s;

  assign mar_mmio_s  = is_mmio(16'(bus.i_MAR));
  assign mmio_xfer_s = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && mmio_q;
  assign mmio_rdata_s = DATA_W'(mmio_rdata16_s);

  lc3_mmio_regs u_mmio (
    .clk      (i_CLK),
    .rst_n    (i_Reset),
    .kb_data  (bus.i_kb_data),
    .kb_valid (bus.i_kb_valid),
    .addr     (16'(addr_q)),
    .wdata    (16'(wdata_q)),
    .xfer     (mmio_xfer_s),
    .rw       (rw_q),
    .rdata    (mmio_rdata16_s),
    .dd_data  (bus.o_dd_data),
    .dd_valid (bus.o_dd_valid),
    .kb_int   (bus.o_kb_int)
  );
`else
  logic kb_unused_s;

  assign mar_mmio_s     = 1'b0;
  assign mmio_rdata_s   = '0;
  assign kb_unused_s    = ^{bus.i_kb_data, bus.i_kb_valid};
  assign bus.o_dd_data  = 8'd0;
  assign bus.o_dd_valid = 1'b0;
  assign bus.o_kb_int   = 1'b0;
`endif

  // Next-state, latches and registered SRAM/R outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    mmio_d  = mmio_q;
    mdr_d   = mdr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_MIO_EN) begin
          addr_d  = bus.i_MAR;
          wdata_d = bus.i_MDR;
          rw_d    = bus.i_R_W;
          mmio_d  = mar_mmio_s;
          cnt_d   = mar_mmio_s ? 4'd0 : CNT_LOAD;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!rw_q) begin
            mdr_d = mmio_q ? mmio_rdata_s : bus.i_mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ce_d = (state_d == ST_ACCESS) && !mmio_d;
    we_d = ce_d && rw_d;
    r_d  = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      mmio_q  <= 1'b0;
      mdr_q   <= '0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      mmio_q  <= mmio_d;
      mdr_q   <= mdr_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      r_q     <= r_d;
    end
  end

  assign bus.o_MDR_in    = mdr_q;
  assign bus.o_R_Bit     = r_q;
  assign bus.o_mem_ce    = ce_q;
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_memory_ctrl.sv
// Scoreboard bench for lc3_memory_ctrl: stimulus queues expected R pulses,
// SRAM beats and display writes; a negedge monitor pops and compares them.
module tb_lc3_memory_ctrl;
  import lc3_mem_pkg::*;

  localparam int W = 2;

  typedef struct { int cyc; logic [15:0] mdr; } r_exp_t;
  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } beat_t;
  typedef struct { int cyc; logic [7:0] data; } dd_exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_mdr;
  logic [15:0] mem [int];

  r_exp_t  r_q[$];
  beat_t   ce_q[$];
  dd_exp_t dd_q[$];

  lc3_mem_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_memory_ctrl #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
    .i_CLK   (clk),
    .i_Reset (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    case (a)
      16'h3000: return 16'h1234;
      16'h3001: return 16'h5678;
      16'hFE00: return 16'h0BAD;
      default:  return 16'h0000;
    endcase
  endfunction

  // SRAM model: write on the clock edge, read data presented from mid-cycle
  initial forever begin
    @(posedge clk);
    if (bus.o_mem_ce && bus.o_mem_we) mem[int'(bus.o_mem_addr)] = bus.o_mem_wdata;
  end

  initial forever begin
    @(negedge clk);
    bus.i_mem_rdata = sram_rd(bus.o_mem_addr);
  end

  // Monitor: compare every R pulse, SRAM beat and display strobe against the queues
  initial begin
    r_exp_t  re;
    beat_t   be;
    dd_exp_t de;
    forever begin
      @(negedge clk);
      if (bus.o_R_Bit) begin
        if (r_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_r: R high in cycle %0d, required low", cyc);
        end else begin
          re = r_q.pop_front();
          chk("r_cycle", cyc, re.cyc);
          chk("mdr_at_r", {16'd0, bus.o_MDR_in}, {16'd0, re.mdr});
        end
      end
      if (bus.o_mem_ce) begin
        if (ce_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ce: addr %h in cycle %0d, required ce low", bus.o_mem_addr, cyc);
        end else begin
          be = ce_q.pop_front();
          chk("sram_we", {31'd0, bus.o_mem_we}, {31'd0, be.we});
          chk("sram_addr", {16'd0, bus.o_mem_addr}, {16'd0, be.addr});
          if (be.we) chk("sram_wdata", {16'd0, bus.o_mem_wdata}, {16'd0, be.data});
        end
      end
      if (bus.o_dd_valid) begin
        if (dd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_dd: dd_valid in cycle %0d, required low", cyc);
        end else begin
          de = dd_q.pop_front();
          chk("dd_cycle", cyc, de.cyc);
          chk("dd_data", {24'd0, bus.o_dd_data}, {24'd0, de.data});
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && r_q.size() != 0; i++) @(posedge clk);
    chk("r_pending", r_q.size(), 0);
    r_q.delete();
  endtask

  task automatic access(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] rd, input bit sram, input bit scramble);
    int      t0;
    int      lat;
    r_exp_t  re;
    beat_t   be;
    dd_exp_t de;
    @(negedge clk);
    bus.i_MIO_EN = 1'b1;
    bus.i_R_W    = rw;
    bus.i_MAR    = addr;
    bus.i_MDR    = wd;
    t0  = cyc;
    lat = sram ? W : 1;
    if (!rw) exp_mdr = rd;
    re.cyc = t0 + lat + 1;
    re.mdr = exp_mdr;
    r_q.push_back(re);
    if (sram) begin
      for (int i = 0; i < lat; i++) begin
        be.we = rw; be.addr = addr; be.data = wd;
        ce_q.push_back(be);
      end
    end
    if (!sram && rw && addr == DDR_ADDR) begin
      de.cyc = t0 + 2; de.data = wd[7:0];
      dd_q.push_back(de);
    end
    @(negedge clk);
    bus.i_MIO_EN = 1'b0;
    if (scramble) begin
      bus.i_MAR = 16'h5555;
      bus.i_MDR = 16'hDEAD;
      bus.i_R_W = ~rw;
    end
    drain();
  endtask

  task automatic kb_press(input logic [7:0] ch);
    @(negedge clk);
    bus.i_kb_valid = 1'b1;
    bus.i_kb_data  = ch;
    @(negedge clk);
    bus.i_kb_valid = 1'b0;
  endtask

  initial begin
    int     t0;
    r_exp_t re;
    beat_t  be;
    n_cmp = 0; n_err = 0; exp_mdr = 16'h0000;
    rst_n = 1'b0;
    bus.i_MIO_EN = 1'b0; bus.i_R_W = 1'b0; bus.i_MAR = 16'h0000; bus.i_MDR = 16'h0000;
    bus.i_kb_data = 8'h00; bus.i_kb_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_r", {31'd0, bus.o_R_Bit}, 32'd0);
    chk("rst_ce", {31'd0, bus.o_mem_ce}, 32'd0);
    chk("rst_we", {31'd0, bus.o_mem_we}, 32'd0);
    chk("rst_mdr", {16'd0, bus.o_MDR_in}, 32'd0);
    chk("rst_addr", {16'd0, bus.o_mem_addr}, 32'd0);
    chk("rst_dd_valid", {31'd0, bus.o_dd_valid}, 32'd0);
    chk("rst_kb_int", {31'd0, bus.o_kb_int}, 32'd0);
    rst_n = 1'b1;

    access(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 1'b0);
    access(1'b1, 16'h4000, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    #1 chk("mdr_hold_after_write", {16'd0, bus.o_MDR_in}, 32'h1234);
    access(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 1'b1);
    access(1'b0, 16'h4000, 16'h0000, 16'hBEEF, 1'b1, 1'b0);

    // Back-to-back: MIO_EN held through DONE starts a second read of x3001
    @(negedge clk);
    bus.i_MIO_EN = 1'b1; bus.i_R_W = 1'b0; bus.i_MAR = 16'h3000; bus.i_MDR = 16'h0000;
    t0 = cyc;
    re.cyc = t0 + 3; re.mdr = 16'h1234; r_q.push_back(re);
    re.cyc = t0 + 7; re.mdr = 16'h5678; r_q.push_back(re);
    be.we = 1'b0; be.data = 16'h0000;
    be.addr = 16'h3000; ce_q.push_back(be); ce_q.push_back(be);
    be.addr = 16'h3001; ce_q.push_back(be); ce_q.push_back(be);
    exp_mdr = 16'h5678;
    @(negedge clk);
    bus.i_MAR = 16'h3001;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.i_MIO_EN = 1'b0;
    drain();

`ifdef LC3_MMIO_EN
    kb_press(8'h41);
    access(1'b0, KBSR_ADDR, 16'h0000, 16'h8000, 1'b0, 1'b0);
    access(1'b0, KBDR_ADDR, 16'h0000, 16'h0041, 1'b0, 1'b0);
    access(1'b0, KBSR_ADDR, 16'h0000, 16'h0000, 1'b0, 1'b0);
    access(1'b0, DSR_ADDR, 16'h0000, 16'h8000, 1'b0, 1'b0);
    access(1'b1, DDR_ADDR, 16'h0042, 16'h0000, 1'b0, 1'b0);
    access(1'b1, KBSR_ADDR, 16'h4000, 16'h0000, 1'b0, 1'b0);
    chk("kb_int_idle", {31'd0, bus.o_kb_int}, 32'd0);
    kb_press(8'h5A);
    chk("kb_int_set", {31'd0, bus.o_kb_int}, 32'd1);
`else
    kb_press(8'h41);
    access(1'b0, KBSR_ADDR, 16'h0000, 16'h0BAD, 1'b1, 1'b0);
    chk("kb_int_tied", {31'd0, bus.o_kb_int}, 32'd0);
    chk("dd_data_tied", {24'd0, bus.o_dd_data}, 32'd0);
`endif

    // Reset during a write: we drops at once, no R follows, MDR_in clears
    @(negedge clk);
    bus.i_MIO_EN = 1'b1; bus.i_R_W = 1'b1; bus.i_MAR = 16'h4000; bus.i_MDR = 16'h1111;
    be.we = 1'b1; be.addr = 16'h4000; be.data = 16'h1111; ce_q.push_back(be);
    @(negedge clk);
    bus.i_MIO_EN = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, bus.o_mem_we}, 32'd0);
    chk("abort_ce", {31'd0, bus.o_mem_ce}, 32'd0);
    chk("abort_mdr", {16'd0, bus.o_MDR_in}, 32'd0);
    exp_mdr = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_mdr_after", {16'd0, bus.o_MDR_in}, 32'd0);

    chk("ce_q_empty", ce_q.size(), 0);
    chk("dd_q_empty", dd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
